// File: rtl/popcnt_pkg.sv
// Shared constants and state type for the sequential population counter.
// Sizing helpers take the word width so every user derives them the same way.
package popcnt_pkg;

    localparam int GROUP = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles: one per 5-bit group, final group zero-padded.
    function automatic int calc_nstep(input int w);
        return (w + GROUP - 1) / GROUP;
    endfunction

    function automatic int calc_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcnt_cnt5.sv
// Combinational ones counter for five bits (result 0..5).
// Two half-adder pairs feed a generate/propagate merge of the weight-1 and weight-2 columns.
module cnt5 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    output logic [2:0] sum
);

    logic s_ab, c_ab, s_cd, c_cd;
    logic p1, g1, k1;
    logic p2, g2;

    assign s_ab = a ^ b;
    assign c_ab = a & b;
    assign s_cd = c ^ d;
    assign c_cd = c & d;

    // Weight-1 column: k1 is the carry into weight 2 from s_ab, s_cd and e.
    assign p1 = s_ab ^ s_cd;
    assign g1 = s_ab & s_cd;
    assign k1 = g1 | (p1 & e);

    assign p2 = c_ab ^ c_cd;
    assign g2 = c_ab & c_cd;

    assign sum[0] = p1 ^ e;
    assign sum[1] = p2 ^ k1;
    assign sum[2] = g2 | (p2 & k1);

endmodule

// File: rtl/popcnt_seq.sv
// Sequential population counter: consumes a W-bit word five bits per clock
// through a single cnt5, then presents the count on a valid/ready output.
module popcnt_seq
    import popcnt_pkg::*;
#(
    parameter  int W     = 32,
    localparam int CNT_W = calc_cnt_w(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int NSTEP  = calc_nstep(W);
    localparam int SH_W   = NSTEP * GROUP;
    localparam int STEP_W = $clog2(NSTEP + 1);

    state_t             state;
    logic [SH_W-1:0]    shreg;
    logic [CNT_W-1:0]   acc;
    logic [STEP_W-1:0]  step;
    logic [2:0]         grp_sum;
    logic [CNT_W-1:0]   acc_next;

    cnt5 u_cnt5 (
        .a   (shreg[0]),
        .b   (shreg[1]),
        .c   (shreg[2]),
        .d   (shreg[3]),
        .e   (shreg[4]),
        .sum (grp_sum)
    );

    assign acc_next = acc + CNT_W'(grp_sum);

    // All outputs are registered; in_ready/busy are loaded with the decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        shreg    <= SH_W'(in_data);
                        acc      <= '0;
                        step     <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    shreg <= shreg >> GROUP;
                    acc   <= acc_next;
                    step  <= step + 1'b1;
                    if (step == STEP_W'(NSTEP - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_count <= acc_next;
                    end
                end
                DONE: begin
                    // Handoff edge returns to IDLE only; acceptance waits a cycle.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcnt_seq.sv
// Directed plus randomized bench for popcnt_seq against a bit-loop reference count.
// Inputs are driven and outputs sampled on the falling edge.
module tb_popcnt_seq;

    localparam int W     = 32;
    localparam int CNT_W = $clog2(W + 1);
    localparam int NSTEP = (W + 4) / 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    popcnt_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_popcount(input logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i < W; i++)
            if (d[i]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feeds one word, follows it through RUN, stalls DONE for `hold` cycles, then hands off.
    task automatic process_word(input logic [W-1:0] data, input int hold, input string tag);
        int expv;
        expv = ref_popcount(data);
        check({tag, " ready before accept"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        check({tag, " busy after accept"}, 64'(busy), 64'd1);
        check({tag, " ready after accept"}, 64'(in_ready), 64'd0);
        for (int k = 1; k < NSTEP; k++) begin
            @(negedge clk);
            check({tag, " early out_valid"}, 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check({tag, " out_valid at latency"}, 64'(out_valid), 64'd1);
        check({tag, " out_count"}, 64'(out_count), 64'(expv));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " held out_valid"}, 64'(out_valid), 64'd1);
            check({tag, " held out_count"}, 64'(out_count), 64'(expv));
            check({tag, " ready in DONE"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = $urandom;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " out_valid after handoff"}, 64'(out_valid), 64'd0);
        check({tag, " busy after handoff"}, 64'(busy), 64'd0);
        check({tag, " ready after handoff"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_count", 64'(out_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset release", 64'(in_ready), 64'd1);

        process_word(32'h0000_0000, 0, "case1 zero");
        process_word(32'hFFFF_FFFF, 0, "case2 ones");
        process_word(32'h8000_0001, 0, "case3 ends");
        process_word(32'h0000_F0F0, 5, "case4 stall");

        for (int r = 0; r < 6; r++)
            process_word(W'($urandom), int'($urandom_range(0, 3)), "random");

        // Abort in the third RUN cycle must discard the word without a result.
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("case5 busy after abort", 64'(busy), 64'd0);
        check("case5 ready after abort", 64'(in_ready), 64'd1);
        check("case5 out_valid after abort", 64'(out_valid), 64'd0);
        for (int k = 0; k < NSTEP + 2; k++) begin
            @(negedge clk);
            check("case5 no result", 64'(out_valid), 64'd0);
        end
        process_word(32'h0000_0007, 1, "case5 follow");

        // Abort together with in_valid in IDLE drops the word.
        in_valid = 1'b1;
        abort    = 1'b1;
        in_data  = 32'h1234_5678;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort in idle busy", 64'(busy), 64'd0);
        check("abort in idle ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-RUN.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("case6 busy in reset", 64'(busy), 64'd0);
        check("case6 out_valid in reset", 64'(out_valid), 64'd0);
        check("case6 ready in reset", 64'(in_ready), 64'd0);
        check("case6 out_count in reset", 64'(out_count), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("case6 ready before edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("case6 ready after first edge", 64'(in_ready), 64'd1);
        check("case6 busy after first edge", 64'(busy), 64'd0);
        @(negedge clk);
        process_word(32'h0F0F_0F0F, 2, "case6 recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
